// File: rtl/branch_pc_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : branch_pc_unit_if
//  Brief    : Fetch handshake, decoded-instruction and PC/status bundle for
//             the branch/PC unit. The slave modport is the unit itself; the
//             master modport is the surrounding pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
interface branch_pc_unit_if;
  // Pipeline -> unit
  logic        fetch_ready_i;
  logic        stall_i;
  logic        is_branch_i;
  logic        is_jal_i;
  logic        is_jalr_i;
  logic [2:0]  funct3_i;
  logic [31:0] imm_i;
  logic [31:0] rs1_data_i;
  logic        br_less_i;
  logic        br_equal_i;
  // Unit -> pipeline
  logic        br_unsigned_o;
  logic [31:0] pc_o;
  logic [31:0] pc_four_o;
  logic        fetch_req_o;
  logic        taken_o;
  logic        misalign_o;
  logic [15:0] br_taken_cnt_o;

  modport slave (
    input  fetch_ready_i, stall_i, is_branch_i, is_jal_i, is_jalr_i,
    input  funct3_i, imm_i, rs1_data_i, br_less_i, br_equal_i,
    output br_unsigned_o, pc_o, pc_four_o, fetch_req_o, taken_o,
    output misalign_o, br_taken_cnt_o
  );

  modport master (
    output fetch_ready_i, stall_i, is_branch_i, is_jal_i, is_jalr_i,
    output funct3_i, imm_i, rs1_data_i, br_less_i, br_equal_i,
    input  br_unsigned_o, pc_o, pc_four_o, fetch_req_o, taken_o,
    input  misalign_o, br_taken_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/branch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : branch_pc_unit
//  Brief    : Program counter and control-transfer resolution. Alternates
//             FETCH/EXEC per instruction, resolves JAL/JALR/conditional
//             branches, diverts misaligned targets through a one-cycle TRAP
//             state, and counts taken conditional branches (saturating).
//  Revision : 1.0 - initial release
// ============================================================================
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  branch_pc_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_TRAP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d;

  logic        cond_met;
  logic        xfer;
  logic        is_cond_br;
  logic [31:0] target;
  logic [31:0] pc_plus_imm;
  logic [31:0] jalr_sum;
  logic [31:0] pc_plus_four;

  assign pc_plus_imm  = pc_q + bus.imm_i;
  assign jalr_sum     = bus.rs1_data_i + bus.imm_i;
  assign pc_plus_four = pc_q + 32'd4;

  // Evaluate the branch condition selected by funct3 from the comparator flags
  always_comb begin
    cond_met = 1'b0;
    case (bus.funct3_i)
      3'b000:          cond_met = bus.br_equal_i;
      3'b001:          cond_met = ~bus.br_equal_i;
      3'b100, 3'b110:  cond_met = bus.br_less_i;
      3'b101, 3'b111:  cond_met = ~bus.br_less_i;
      default:         cond_met = 1'b0;
    endcase
  end

  // Resolve the winning instruction class (JALR over JAL over branch) and its target
  always_comb begin
    xfer       = 1'b0;
    is_cond_br = 1'b0;
    target     = pc_plus_imm;
    if (bus.is_jalr_i) begin
      xfer   = 1'b1;
      target = jalr_sum & ~32'h0000_0001;
    end else if (bus.is_jal_i) begin
      xfer   = 1'b1;
    end else if (bus.is_branch_i) begin
      is_cond_br = 1'b1;
      xfer       = cond_met;
    end
  end

  // Next-state logic: state, PC and taken-branch counter
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_FETCH: begin
        if (bus.fetch_ready_i) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!bus.stall_i) begin
          state_d = S_FETCH;
          if (xfer) begin
            // A target with bit 1 set is not word aligned: keep the PC and trap
            if (target[1]) begin
              state_d = S_TRAP;
            end else begin
              pc_d = target;
            end
          end else begin
            pc_d = pc_plus_four;
          end
          // Trapping taken branches still count
          if (is_cond_br && xfer && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_TRAP: begin
        pc_d    = TRAP_PC;
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State, PC and counter registers with asynchronous reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.br_unsigned_o  = bus.funct3_i[1];
  assign bus.pc_o           = pc_q;
  assign bus.pc_four_o      = pc_plus_four;
  assign bus.fetch_req_o    = (state_q == S_FETCH);
  assign bus.taken_o        = (state_q == S_EXEC) && xfer;
  assign bus.misalign_o     = (state_q == S_TRAP);
  assign bus.br_taken_cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_pc_unit
//  Brief    : Scoreboard bench for branch_pc_unit. The driver issues one
//             instruction at a time, computes the architectural outcome with
//             a reference model and queues it; the monitor compares every
//             EXEC cycle against the queue head.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_pc_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_PC  = 32'h0000_0100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  branch_pc_unit_if bus ();

  branch_pc_unit #(
    .RESET_PC (RESET_PC),
    .TRAP_PC  (TRAP_PC)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic        uns;
    logic        trap;
    logic [15:0] cnt;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_pc;
  logic [15:0] m_cnt;
  logic        mon_en    = 1'b0;
  logic        trap_pend = 1'b0;
  logic [31:0] trap_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural rules: which condition each funct3 encodes
  function automatic logic cond_holds(input logic [2:0] f3, input logic lt, input logic eq);
    case (f3)
      3'b000:         return eq;
      3'b001:         return !eq;
      3'b100, 3'b110: return lt;
      3'b101, 3'b111: return !lt;
      default:        return 1'b0;
    endcase
  endfunction

  task automatic junk();
    bus.is_branch_i = 1'($urandom_range(0, 1));
    bus.is_jal_i    = 1'($urandom_range(0, 1));
    bus.is_jalr_i   = 1'($urandom_range(0, 1));
    bus.funct3_i    = 3'($urandom_range(0, 7));
    bus.imm_i       = $urandom;
    bus.rs1_data_i  = $urandom;
    bus.br_less_i   = 1'($urandom_range(0, 1));
    bus.br_equal_i  = 1'($urandom_range(0, 1));
    bus.stall_i     = 1'($urandom_range(0, 1));
  endtask

  // Issue one instruction: fetch handshake, then EXEC with optional stalls
  task automatic do_instr(input logic br, input logic jal, input logic jalr,
                          input logic [2:0] f3, input logic [31:0] imm,
                          input logic [31:0] rs1, input logic lt, input logic eq,
                          input int stalls, input int fwait);
    int          guard;
    exp_t        e;
    logic        taken;
    logic        counts;
    logic [31:0] tgt;
    guard = 0;
    while (!bus.fetch_req_o && guard < 8) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!bus.fetch_req_o) begin
      total++; bad++;
      $display("FAIL fetch_timeout: got fetch_req=0 expected 1 within 8 cycles");
    end
    repeat (fwait) begin
      junk();
      bus.fetch_ready_i = 1'b0;
      @(posedge clk); #1;
    end
    junk();
    bus.fetch_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.fetch_ready_i = 1'($urandom_range(0, 1));
    bus.is_branch_i = br;   bus.is_jal_i   = jal;  bus.is_jalr_i = jalr;
    bus.funct3_i    = f3;   bus.imm_i      = imm;  bus.rs1_data_i = rs1;
    bus.br_less_i   = lt;   bus.br_equal_i = eq;
    // Reference outcome
    counts = 1'b0;
    if (jalr)      begin taken = 1'b1; tgt = (rs1 + imm) & 32'hFFFF_FFFE; end
    else if (jal)  begin taken = 1'b1; tgt = m_pc + imm; end
    else if (br)   begin taken = cond_holds(f3, lt, eq); tgt = m_pc + imm; counts = taken; end
    else           begin taken = 1'b0; tgt = m_pc + imm; end
    e.pc    = m_pc;
    e.taken = taken;
    e.uns   = f3[1];
    e.trap  = taken && tgt[1];
    e.cnt   = m_cnt;
    q.push_back(e);
    if (counts && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (e.trap)      m_pc = TRAP_PC;
    else if (taken)  m_pc = tgt;
    else             m_pc = m_pc + 32'd4;
    bus.stall_i = (stalls > 0);
    for (int i = 0; i < stalls; i++) begin
      @(posedge clk); #1;
    end
    bus.stall_i = 1'b0;
    @(posedge clk); #1;
    junk();
  endtask

  task automatic reset_pulse();
    @(negedge clk); #1;
    mon_en = 1'b0;
    trap_pend = 1'b0;
    bus.is_jal_i = 1'b1;
    bus.fetch_ready_i = 1'b1;
    bus.stall_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_pc",        bus.pc_o,           RESET_PC);
    chk("rst_fetch_req", bus.fetch_req_o,    32'd1);
    chk("rst_misalign",  bus.misalign_o,     32'd0);
    chk("rst_taken",     bus.taken_o,        32'd0);
    chk("rst_cnt",       bus.br_taken_cnt_o, 32'd0);
    #1 rst_n = 1'b1;
    q.delete();
    m_pc  = RESET_PC;
    m_cnt = 16'd0;
    bus.fetch_ready_i = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_pc",        bus.pc_o,        RESET_PC);
    chk("post_rst_fetch_req", bus.fetch_req_o, 32'd1);
    mon_en = 1'b1;
  endtask

  // Monitor: compare the DUT against queued expectations on every falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        trap_pend = 1'b0;
      end else if (trap_pend) begin
        trap_pend = 1'b0;
        chk("trap_misalign",  bus.misalign_o,  32'd1);
        chk("trap_pc_hold",   bus.pc_o,        trap_pc);
        chk("trap_taken",     bus.taken_o,     32'd0);
        chk("trap_fetch_req", bus.fetch_req_o, 32'd0);
      end else if (bus.fetch_req_o) begin
        chk("fetch_taken",    bus.taken_o,       32'd0);
        chk("fetch_misalign", bus.misalign_o,    32'd0);
        chk("fetch_unsigned", bus.br_unsigned_o, {31'd0, bus.funct3_i[1]});
      end else if (bus.misalign_o) begin
        chk("unexpected_trap", bus.misalign_o, 32'd0);
      end else if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL exec_without_instr: got EXEC expected no instruction at %0t", $time);
      end else begin
        e = q[0];
        chk("exec_pc",       bus.pc_o,           e.pc);
        chk("exec_pc_four",  bus.pc_four_o,      e.pc + 32'd4);
        chk("exec_taken",    bus.taken_o,        {31'd0, e.taken});
        chk("exec_unsigned", bus.br_unsigned_o,  {31'd0, e.uns});
        chk("exec_cnt",      bus.br_taken_cnt_o, {16'd0, e.cnt});
        if (!bus.stall_i) begin
          void'(q.pop_front());
          if (e.trap) begin
            trap_pend = 1'b1;
            trap_pc   = e.pc;
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #50_000_000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.fetch_ready_i = 1'b0;
    junk();
    reset_pulse();

    // Sequential run: 0, 4, 8 with no class inputs
    for (int i = 0; i < 3; i++) do_instr(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 1, 0, 0);
    // JAL 0xC -> 0x40, then taken BEQ back to 0x30
    do_instr(0, 1, 0, 3'b000, 32'h0000_0034, 32'h0, 0, 0, 0, 0);
    do_instr(1, 0, 0, 3'b000, 32'hFFFF_FFF0, 32'h0, 0, 1, 0, 1);
    chk("beq_pc",  bus.pc_o,           32'h0000_0030);
    chk("beq_cnt", bus.br_taken_cnt_o, 32'd1);
    // JAL to 0x10, then JALR+JAL with misaligned target 0x202
    do_instr(0, 1, 0, 3'b000, 32'hFFFF_FFE0, 32'h0, 0, 0, 0, 0);
    do_instr(0, 1, 1, 3'b000, 32'h0, 32'h0000_0203, 0, 0, 0, 0);
    chk("jalr_trap_flag", bus.misalign_o, 32'd1);
    chk("jalr_trap_pc",   bus.pc_o,       32'h0000_0010);
    @(posedge clk); #1;
    chk("trap_dest_pc",   bus.pc_o,           TRAP_PC);
    chk("trap_cnt",       bus.br_taken_cnt_o, 32'd1);
    // BLTU taken with three stall cycles: 0x100 -> 0x120
    do_instr(1, 0, 0, 3'b110, 32'h0000_0020, 32'h0, 1, 0, 3, 1);
    chk("bltu_pc",  bus.pc_o,           32'h0000_0120);
    chk("bltu_cnt", bus.br_taken_cnt_o, 32'd2);
    // PC wrap: JAL to 0xFFFF_FFFC, fall through to 0
    do_instr(0, 1, 0, 3'b000, 32'hFFFF_FEDC, 32'h0, 0, 0, 0, 0);
    do_instr(0, 0, 0, 3'b010, 32'h0, 32'h0, 1, 1, 0, 0);
    chk("wrap_pc", bus.pc_o, 32'h0);

    // Randomised instruction stream
    for (int i = 0; i < 400; i++) begin
      do_instr(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
               $urandom & 32'hFFFF_FFFE, $urandom,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Reset asserted between edges during a TRAP cycle
    do_instr(0, 1, 0, 3'b000, 32'h0000_0002, 32'h0, 0, 0, 0, 0);
    chk("pre_rst_trap", bus.misalign_o, 32'd1);
    reset_pulse();
    do_instr(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 0, 0);

    // Counter saturation
    reset_pulse();
    for (int i = 0; i < 65535; i++) do_instr(1, 0, 0, 3'b000, 32'h8, 32'h0, 0, 1, 0, 0);
    chk("sat_preload", bus.br_taken_cnt_o, 32'h0000_FFFF);
    do_instr(1, 0, 0, 3'b001, 32'h8, 32'h0, 0, 0, 0, 0);
    chk("sat_hold", bus.br_taken_cnt_o, 32'h0000_FFFF);
    do_instr(0, 1, 0, 3'b000, 32'h8, 32'h0, 0, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    chk("final_cnt", bus.br_taken_cnt_o, {16'd0, m_cnt});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
